// File: rtl/mandelbrot_pkg.sv
// Shared constants and FSM state type for the Mandelbrot frame scheduler.
// Coordinates are 4.23 two's complement fixed point.
package mandelbrot_pkg;

   localparam int COORD_W     = 27;
   localparam int ITER_W      = 10;
   localparam int NUM_SOLVERS = 4;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int BASE_STEP   = 39322;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      CALC,
      START,
      RUN,
      DONE
   } zoom_state_t;

endpackage

// File: rtl/mandelbrot_zoom_scheduler_view_param_calc.sv
// Combinational view geometry: per-pixel step from the zoom level and the
// top-left pixel coordinate derived from the view centre.
module view_param_calc #(
   parameter int COORD_W   = mandelbrot_pkg::COORD_W,
   parameter int BASE_STEP = mandelbrot_pkg::BASE_STEP
) (
   input  logic [3:0]         zoom_sh,
   input  logic [COORD_W-1:0] cx_sh,
   input  logic [COORD_W-1:0] cy_sh,
   output logic [COORD_W-1:0] step,
   output logic [COORD_W-1:0] x_start,
   output logic [COORD_W-1:0] y_start
);
   import mandelbrot_pkg::*;

   localparam logic [COORD_W-1:0] BASE = COORD_W'(BASE_STEP);

   logic [COORD_W-1:0] half_w;
   logic [COORD_W-1:0] half_h;

   // 320*step and 240*step as shift/add; everything wraps modulo 2^COORD_W
   assign step    = BASE >> zoom_sh;
   assign half_w  = (step << 8) + (step << 6);
   assign half_h  = (step << 8) - (step << 4);
   assign x_start = cx_sh - half_w;
   assign y_start = cy_sh - half_h;

endmodule

// File: rtl/mandelbrot_zoom_scheduler.sv
// Frame sequencer between the HPS view-control PIOs and the solver array:
// latches view controls, computes geometry, starts solvers and times the frame.
module mandelbrot_zoom_scheduler #(
   parameter int COORD_W     = mandelbrot_pkg::COORD_W,
   parameter int NUM_SOLVERS = mandelbrot_pkg::NUM_SOLVERS,
   parameter int BASE_STEP   = mandelbrot_pkg::BASE_STEP,
   parameter int ITER_W      = mandelbrot_pkg::ITER_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             zoom_num,
   input  logic [COORD_W-1:0]     center_x,
   input  logic [COORD_W-1:0]     center_y,
   input  logic [ITER_W-1:0]      max_iter_in,
   input  logic [NUM_SOLVERS-1:0] solver_done,
   output logic                   solver_start,
   output logic [COORD_W-1:0]     x_start,
   output logic [COORD_W-1:0]     y_start,
   output logic [COORD_W-1:0]     step,
   output logic [ITER_W-1:0]      max_iter,
   output logic                   busy,
   output logic [31:0]            frame_cycles,
   output logic [15:0]            frame_count
);
   import mandelbrot_pkg::*;

   zoom_state_t            state;
   zoom_state_t            state_next;
   logic                   pending;
   logic [3:0]             zoom_sh;
   logic [COORD_W-1:0]     cx_sh;
   logic [COORD_W-1:0]     cy_sh;
   logic [ITER_W-1:0]      iter_sh;
   logic [NUM_SOLVERS-1:0] done_seen;
   logic [NUM_SOLVERS-1:0] done_seen_next;
   logic [31:0]            cycle_ctr;
   logic [COORD_W-1:0]     calc_step;
   logic [COORD_W-1:0]     calc_x;
   logic [COORD_W-1:0]     calc_y;
   logic                   view_changed;

   view_param_calc #(
      .COORD_W   (COORD_W),
      .BASE_STEP (BASE_STEP)
   ) u_view_param_calc (
      .zoom_sh (zoom_sh),
      .cx_sh   (cx_sh),
      .cy_sh   (cy_sh),
      .step    (calc_step),
      .x_start (calc_x),
      .y_start (calc_y)
   );

   assign view_changed   = (zoom_num != zoom_sh) || (center_x != cx_sh) ||
                           (center_y != cy_sh) || (max_iter_in != iter_sh);
   assign done_seen_next = done_seen | solver_done;
   assign max_iter       = iter_sh;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      solver_start = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (pending || view_changed) begin
               state_next = LATCH;
            end
         end
         LATCH: begin
            busy       = 1'b1;
            state_next = CALC;
         end
         CALC: begin
            busy       = 1'b1;
            state_next = START;
         end
         START: begin
            busy         = 1'b1;
            solver_start = 1'b1;
            state_next   = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (&done_seen_next) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shadows only move in LATCH, so solvers never see PIO changes mid-frame
   always_ff @(posedge clk) begin
      if (reset) begin
         pending      <= 1'b1;
         zoom_sh      <= '0;
         cx_sh        <= '0;
         cy_sh        <= '0;
         iter_sh      <= '0;
         step         <= '0;
         x_start      <= '0;
         y_start      <= '0;
         done_seen    <= '0;
         cycle_ctr    <= '0;
         frame_cycles <= '0;
         frame_count  <= '0;
      end else begin
         case (state)
            LATCH: begin
               zoom_sh <= zoom_num;
               cx_sh   <= center_x;
               cy_sh   <= center_y;
               iter_sh <= max_iter_in;
               pending <= 1'b0;
            end
            CALC: begin
               step    <= calc_step;
               x_start <= calc_x;
               y_start <= calc_y;
            end
            START: begin
               done_seen <= '0;
               cycle_ctr <= '0;
            end
            RUN: begin
               done_seen <= done_seen_next;
               if (cycle_ctr != '1) begin
                  cycle_ctr <= cycle_ctr + 32'd1;
               end
            end
            DONE: begin
               frame_cycles <= cycle_ctr + 32'd1;
               frame_count  <= frame_count + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
